// File: rtl/filter_fir_inverse.sv
// filter_fir_inverse: bit-exact inverse of the team's recursive link filter.
// Recovers NB_OUTPUT-bit samples with one-cycle latency. Define FILTER_INV_SAT_EN for output clamping and the saturation counter.

module filter_fir_inverse #(
  parameter int NB_INPUT  = 12,
  parameter int NB_OUTPUT = 8,
  parameter int NB_ACC    = 14,
  parameter int NB_CNT    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic signed [NB_INPUT-1:0]  y,
  output logic                        out_valid,
  output logic signed [NB_OUTPUT-1:0] x_hat,
  output logic                        sat,
  output logic [NB_CNT-1:0]           sat_count
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic                        accept;

  logic signed [NB_INPUT-1:0]  y1_q, y2_q;
  logic signed [NB_OUTPUT-1:0] x1_q, x2_q, x3_q;
  logic signed [NB_INPUT-1:0]  y1_sh, y2_sh;
  logic signed [NB_ACC-1:0]    acc;
  logic signed [NB_OUTPUT-1:0] x_d;
  logic                        sat_d;

  logic                        out_valid_q;
  logic signed [NB_OUTPUT-1:0] x_hat_q;
  logic                        sat_q;

  function automatic logic signed [NB_ACC-1:0] sext_in(input logic signed [NB_INPUT-1:0] v);
    return {{(NB_ACC-NB_INPUT){v[NB_INPUT-1]}}, v};
  endfunction

  function automatic logic signed [NB_ACC-1:0] sext_out(input logic signed [NB_OUTPUT-1:0] v);
    return {{(NB_ACC-NB_OUTPUT){v[NB_OUTPUT-1]}}, v};
  endfunction

`ifdef FILTER_INV_SAT_EN
  localparam logic signed [NB_ACC-1:0]    ACC_MAX = NB_ACC'((1 << (NB_OUTPUT-1)) - 1);
  localparam logic signed [NB_ACC-1:0]    ACC_MIN = -NB_ACC'(1 << (NB_OUTPUT-1));
  localparam logic signed [NB_OUTPUT-1:0] OUT_MAX = {1'b0, {(NB_OUTPUT-1){1'b1}}};
  localparam logic signed [NB_OUTPUT-1:0] OUT_MIN = {1'b1, {(NB_OUTPUT-1){1'b0}}};

  function automatic logic is_sat(input logic signed [NB_ACC-1:0] a);
    return (a > ACC_MAX) || (a < ACC_MIN);
  endfunction

  function automatic logic signed [NB_OUTPUT-1:0] clamp(input logic signed [NB_ACC-1:0] a);
    if (a > ACC_MAX) return OUT_MAX;
    if (a < ACC_MIN) return OUT_MIN;
    return a[NB_OUTPUT-1:0];
  endfunction
`endif

  // Shifts act on the stored NB_INPUT-bit values so truncation matches the forward filter.
  always_comb begin
    y1_sh = y1_q >>> 1;
    y2_sh = y2_q >>> 2;
    acc   = sext_in(y) - sext_in(y1_sh) - sext_in(y2_sh)
          + sext_out(x1_q) - sext_out(x2_q) - sext_out(x3_q);
  end

`ifdef FILTER_INV_SAT_EN
  always_comb begin
    x_d   = clamp(acc);
    sat_d = is_sat(acc);
  end
`else
  logic acc_unused_hi;
  always_comb begin
    x_d           = acc[NB_OUTPUT-1:0];
    sat_d         = 1'b0;
    acc_unused_hi = ^acc[NB_ACC-1:NB_OUTPUT];
  end
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = IDLE;
        end else if (in_valid) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_d = IDLE;
        end else if (in_valid) begin
          accept = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result register stage: history shift and outputs, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      y1_q        <= '0;
      y2_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      out_valid_q <= 1'b0;
      x_hat_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        y2_q    <= y1_q;
        y1_q    <= y;
        x3_q    <= x2_q;
        x2_q    <= x1_q;
        x1_q    <= x_d;
        x_hat_q <= x_d;
        sat_q   <= sat_d;
      end
    end
  end

`ifdef FILTER_INV_SAT_EN
  logic [NB_CNT-1:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (accept && sat_d && (sat_cnt_q != {NB_CNT{1'b1}})) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

  assign out_valid = out_valid_q;
  assign x_hat     = x_hat_q;
  assign sat       = sat_q;

endmodule

// File: doc/filter_fir_inverse.md
# filter_fir_inverse

Recovers the original 8-bit sample stream from the 12-bit output of the team's fixed-point recursive filter, y[n] = x[n] − x[n−1] + x[n−2] + x[n−3] + (y[n−1]>>>1) + (y[n−2]>>>2). It sits at the far end of the filtered link, either as the equaliser in the receive path or as the loop-back checker in the verification environment. It reconstructs x[n] bit-exactly using a registered, valid-qualified pipeline, a two-state control FSM and saturation bookkeeping.

## Interface
- NB_INPUT, 12, width of the filtered input sample y (signed two's complement)
- NB_OUTPUT, 8, width of the recovered sample x_hat (signed two's complement)
- NB_ACC, 14, internal accumulator width (must be at least NB_INPUT+2)
- NB_CNT, 8, width of the saturation event counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset rst_n, synchronous, active-low
- clear  in  1  synchronous flush of history, FSM and counter
- in_valid  in  1  y is a new sample this cycle
- y  in  NB_INPUT  filtered sample
- out_valid  out  1  x_hat holds a new recovered sample
- x_hat  out  NB_OUTPUT  recovered sample
- sat  out  1  x_hat for this out_valid was clamped
- sat_count  out  NB_CNT  count of clamped samples, sticky at maximum

## Operation
- History registers: y1, y2 (NB_INPUT bits) and x1, x2, x3 (NB_OUTPUT bits), all zero after reset or clear. This matches the zero-initialised forward filter.
- Per accepted sample, the accumulator (NB_ACC bits, all operands sign-extended) is: acc = y − (y1>>>1) − (y2>>>2) + x1 − x2 − x3. Shifts are arithmetic on the NB_INPUT-bit stored values, so the truncation is identical to the forward filter.
- Result: x_new = acc clamped to [−2^(NB_OUTPUT−1), 2^(NB_OUTPUT−1)−1]. sat = 1 when clamping occurred.
- Shift on acceptance: y2←y1, y1←y, x3←x2, x2←x1, x1←x_new. x1 stores the clamped value.
- History does not advance when in_valid is 0.
- FSM states:
  - IDLE: after reset or clear.
  - RUN: entered on the first in_valid in IDLE. That sample is processed normally.
  - RUN → IDLE only on clear.
  - out_valid is asserted only for samples accepted in IDLE or RUN with clear = 0.
- sat_count increments on each out_valid with sat = 1. It holds at 2^NB_CNT−1 and never wraps.
- clear priority: clear = 1 dominates in_valid. A sample presented with clear is dropped, and out_valid = 0 on the next cycle. History, sat_count, sat and x_hat return to 0 and the FSM returns to IDLE.

## Timing
- Latency: one cycle. in_valid with y at edge k gives out_valid, x_hat and sat valid after edge k.
- out_valid is a single-cycle pulse per accepted sample. Back-to-back in_valid gives back-to-back out_valid at full throughput with no stalls.
- x_hat and sat hold their last values while out_valid = 0.
- Reset values (rst_n = 0 at a rising edge): out_valid = 0, x_hat = 0, sat = 0, sat_count = 0, all history = 0, FSM = IDLE.
- Reset mid-stream: the in-flight sample is discarded. The first post-reset sample is computed with zero history.
- rst_n has priority over clear. clear has priority over in_valid.

## Configuration
- FILTER_INV_SAT_EN defined:
  - Clamping is applied as described.
  - sat and sat_count are live.
- FILTER_INV_SAT_EN undefined:
  - x_new = acc[NB_OUTPUT−1:0] (two's-complement wrap), and x1 stores the wrapped value.
  - sat is tied 0 and sat_count is tied 0.
  - The counter logic is not instantiated.

## Test plan
- Impulse: after reset, drive y = 1, −1, 0, 0, 0 with in_valid every cycle → x_hat = 1, 0, 0, 0, 0, each with out_valid, sat = 0.
- Loop-back: drive random x in [−128,127] through a forward-filter model into the block → x_hat equals x delayed by one cycle for 10,000 samples; sat_count = 0.
- Gapped stream: repeat the impulse with in_valid low for 3 cycles between samples → identical x_hat sequence; out_valid is high only on the 5 result cycles; x_hat holds between results.
- Saturation (macro defined): from reset, drive y = 200 → x_hat = 127, sat = 1, sat_count = 1. Next y = 0 → acc = 0 − 100 − 0 + 127 = 27, x_hat = 27, sat = 0.
  - Same stimulus with the macro undefined → x_hat = −56, then next y = 0 → acc = −100 − 56 = −156, x_hat = 100, sat = 0.
- Counter stickiness: 300 saturating samples → sat_count = 255 and stays 255.
- Clear and reset:
  - clear together with in_valid mid-stream → no out_valid on the next cycle; sat_count = 0; the next sample y = 5 gives x_hat = 5.
  - rst_n low for one cycle during a burst → all outputs 0 on the next cycle.
